hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised forwarding and load-use hazard unit for the pipelined processor. It selects bypass sources for both EX-stage ALU operands across NSRC in-flight write-back stages. It also detects load-use hazards against the ID stage and holds the front end for LOAD_LAT cycles through a small stall FSM. A saturating stall-cycle counter is exposed for performance measurement.

## Interface
- REG_AW, 5: register-address width.
- NSRC, 2: number of forwarding sources; index 0 is the youngest (EX/MEM), index 1 is MEM/WB, and so on.
- LOAD_LAT, 1: stall cycles per load-use hazard; legal range 1..15.
- SELW, $clog2(NSRC+1): derived local parameter, the width of the forward selects.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_we  in  NSRC  register-write enable of each source stage.
- src_rd  in  NSRC*REG_AW  destination register of each source; source k occupies bits [k*REG_AW +: REG_AW].
- idex_rs, idex_rt  in  REG_AW  source registers of the instruction in EX.
- ifid_rs, ifid_rt  in  REG_AW  source registers of the instruction in ID.
- ifid_rs_used, ifid_rt_used  in  1  the ID instruction actually reads that operand.
- idex_mem_read  in  1  the EX instruction is a load.
- idex_rd  in  REG_AW  destination register of the EX instruction.
- flush  in  1  taken branch or jump; aborts any stall in progress.
- freeze  in  1  global pipeline freeze (memory busy); the stall counter holds.
- forward_a, forward_b  out  SELW  operand select; 0 selects the register file, k+1 selects source k.
- stall  out  1  hold PC and the IF/ID register.
- bubble  out  1  insert a NOP into ID/EX.
- stall_cycles  out  16  saturating count of cycles with stall asserted.

## Operation
- Forwarding is combinational. Source k matches operand X when src_we[k]=1, src_rd[k]==X and src_rd[k]!=0.
  - forward_a is k+1 for the lowest matching k (youngest stage wins), else 0.
  - forward_b is computed the same way against idex_rt.
- A hazard exists when all of the following hold:
  - idex_mem_read=1 and idex_rd!=0;
  - (ifid_rs_used and ifid_rs==idex_rd) or (ifid_rt_used and ifid_rt==idex_rd).
- The FSM has two states, IDLE and STALL, and a 4-bit down-counter cnt.
  - IDLE with hazard and no flush: stall=bubble=1 in the same cycle. If LOAD_LAT>1, load cnt=LOAD_LAT-1 and go to STALL; otherwise stay in IDLE.
  - STALL: stall=bubble=1. If freeze=1, hold state and cnt. Otherwise decrement cnt; at cnt==1, return to IDLE on that edge.
  - flush=1 in any state forces stall=bubble=0 combinationally and sends the FSM to IDLE with cnt=0. Flush has priority over hazard and over freeze.
  - The bubble empties ID/EX, so the hazard cannot re-trigger on the same load.
- stall_cycles increments on every edge where stall=1 and saturates at 16'hFFFF. It is not affected by flush.

## Timing
- forward_a and forward_b have zero latency: they are a pure function of the current inputs, including during reset.
- stall and bubble are asserted in the same cycle the hazard appears.
- Each hazard produces exactly LOAD_LAT consecutive stall cycles, extended by any freeze cycles that occur in STALL.
- During reset: state=IDLE, cnt=0, stall_cycles=0, and stall=bubble=0 regardless of the hazard inputs.
- Reset asserted mid-stall clears the FSM immediately (asynchronously). The first cycle after reset release re-evaluates the hazard from the inputs alone.
- freeze in IDLE has no effect on detection; the pipeline itself is responsible for holding.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, STALL);
  - the forward-select encoding constant FWD_RF=0;
  - the stall-counter width constant STALLW=16.
- One sub-module, fwd_select, implements the priority match for a single operand and is instantiated twice (operand A and operand B).
- The FSM, the load-use comparator and the statistics counter live in the top module.

## Test plan
- NSRC=2: src_we=2'b11, src_rd[0]=src_rd[1]=5'd8, idex_rs=8 -> forward_a=1 (youngest wins). Then clear src_we[0] -> forward_a=2.
- src_we=1, src_rd[0]=0, idex_rs=0 -> forward_a=0 (r0 never forwarded).
- LOAD_LAT=1, idex_mem_read=1, idex_rd=9, ifid_rs=9, ifid_rs_used=1 -> stall=bubble=1 for exactly one cycle; stall_cycles=1.
- LOAD_LAT=3, hazard as above, freeze=1 on the second stall cycle -> four stall cycles total; stall_cycles=4.
- LOAD_LAT=3, hazard, then flush=1 on the second cycle -> stall=0 in that cycle and FSM back to IDLE. Also: ifid_rt==idex_rd with ifid_rt_used=0 -> no stall.
- Assert rst during STALL -> stall=0 immediately, stall_cycles=0. Separately, force 70000 stall cycles -> stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package hazard_forward_unit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  localparam int STALLW = 16;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-facing signal bundle of the hazard unit; master drives the pipeline view, slave is the unit.
interface hazard_forward_unit_if
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2
);
  localparam int SELW = $clog2(NSRC + 1);

  logic [NSRC-1:0]        src_we;
  logic [NSRC*REG_AW-1:0] src_rd;
  logic [REG_AW-1:0]      idex_rs;
  logic [REG_AW-1:0]      idex_rt;
  logic [REG_AW-1:0]      ifid_rs;
  logic [REG_AW-1:0]      ifid_rt;
  logic                   ifid_rs_used;
  logic                   ifid_rt_used;
  logic                   idex_mem_read;
  logic [REG_AW-1:0]      idex_rd;
  logic                   flush;
  logic                   freeze;
  logic [SELW-1:0]        forward_a;
  logic [SELW-1:0]        forward_b;
  logic                   stall;
  logic                   bubble;
  logic [STALLW-1:0]      stall_cycles;

  modport master (
    output src_we, src_rd, idex_rs, idex_rt, ifid_rs, ifid_rt,
           ifid_rs_used, ifid_rt_used, idex_mem_read, idex_rd, flush, freeze,
    input  forward_a, forward_b, stall, bubble, stall_cycles
  );

  modport slave (
    input  src_we, src_rd, idex_rs, idex_rt, ifid_rs, ifid_rt,
           ifid_rs_used, ifid_rt_used, idex_mem_read, idex_rd, flush, freeze,
    output forward_a, forward_b, stall, bubble, stall_cycles
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority bypass select for one EX operand; purely combinational, youngest matching source wins.
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int SELW   = $clog2(NSRC + 1)
) (
  input  logic [NSRC-1:0]        src_we_i,
  input  logic [NSRC*REG_AW-1:0] src_rd_i,
  input  logic [REG_AW-1:0]      op_i,
  output logic [SELW-1:0]        sel_o
);

  always_comb begin
    sel_o = SELW'(FWD_RF);
    // Walk oldest to youngest so the youngest match overwrites last.
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (src_we_i[k] &&
          (src_rd_i[k*REG_AW +: REG_AW] == op_i) &&
          (src_rd_i[k*REG_AW +: REG_AW] != '0)) begin
        sel_o = SELW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding plus load-use stall FSM and saturating stall counter.
// Forward selects and stall/bubble are same-cycle combinational; FSM and counter update on clk.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave bus
);

  localparam int SELW = $clog2(NSRC + 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [STALLW-1:0] stall_cycles_q, stall_cycles_d;
  logic              hazard;
  logic              stall_raw;
  logic              stall_int;

  fwd_select #(.REG_AW(REG_AW), .NSRC(NSRC), .SELW(SELW)) u_fwd_a (
    .src_we_i (bus.src_we),
    .src_rd_i (bus.src_rd),
    .op_i     (bus.idex_rs),
    .sel_o    (bus.forward_a)
  );

  fwd_select #(.REG_AW(REG_AW), .NSRC(NSRC), .SELW(SELW)) u_fwd_b (
    .src_we_i (bus.src_we),
    .src_rd_i (bus.src_rd),
    .op_i     (bus.idex_rt),
    .sel_o    (bus.forward_b)
  );

  assign hazard = bus.idex_mem_read && (bus.idex_rd != '0) &&
                  ((bus.ifid_rs_used && (bus.ifid_rs == bus.idex_rd)) ||
                   (bus.ifid_rt_used && (bus.ifid_rt == bus.idex_rd)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard) begin
            stall_raw = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = 4'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          stall_raw = 1'b1;
          if (!bus.freeze) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Comparator is live during reset, so the reset term must mask it here.
  assign stall_int = stall_raw && !rst;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_int && (stall_cycles_q != {STALLW{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + STALLW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall_int;
  assign bus.bubble       = stall_int;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: LOAD_LAT=3 and LOAD_LAT=1 instances share stimulus and are checked against a stall-budget model.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NS-1:0]    src_we = '0;
  logic [NS*AW-1:0] src_rd = '0;
  logic [AW-1:0]    idex_rs = '0, idex_rt = '0, ifid_rs = '0, ifid_rt = '0, idex_rd = '0;
  logic             ifid_rs_used = 1'b0, ifid_rt_used = 1'b0, idex_mem_read = 1'b0;
  logic             flush = 1'b0, freeze = 1'b0;

  int tests  = 0;
  int failed = 0;

  // Model state, index 0 = LOAD_LAT 3 instance, index 1 = LOAD_LAT 1 instance.
  int owed[2];
  int sc[2];
  int lat[2] = '{3, 1};

  hazard_forward_unit_if #(.REG_AW(AW), .NSRC(NS)) if3 ();
  hazard_forward_unit_if #(.REG_AW(AW), .NSRC(NS)) if1 ();

  assign if3.src_we = src_we;               assign if1.src_we = src_we;
  assign if3.src_rd = src_rd;               assign if1.src_rd = src_rd;
  assign if3.idex_rs = idex_rs;             assign if1.idex_rs = idex_rs;
  assign if3.idex_rt = idex_rt;             assign if1.idex_rt = idex_rt;
  assign if3.ifid_rs = ifid_rs;             assign if1.ifid_rs = ifid_rs;
  assign if3.ifid_rt = ifid_rt;             assign if1.ifid_rt = ifid_rt;
  assign if3.ifid_rs_used = ifid_rs_used;   assign if1.ifid_rs_used = ifid_rs_used;
  assign if3.ifid_rt_used = ifid_rt_used;   assign if1.ifid_rt_used = ifid_rt_used;
  assign if3.idex_mem_read = idex_mem_read; assign if1.idex_mem_read = idex_mem_read;
  assign if3.idex_rd = idex_rd;             assign if1.idex_rd = idex_rd;
  assign if3.flush = flush;                 assign if1.flush = flush;
  assign if3.freeze = freeze;               assign if1.freeze = freeze;

  hazard_forward_unit #(.REG_AW(AW), .NSRC(NS), .LOAD_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  hazard_forward_unit #(.REG_AW(AW), .NSRC(NS), .LOAD_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // First source in age order whose write matches a nonzero operand.
  function automatic int exp_fwd(input logic [AW-1:0] op);
    for (int k = 0; k < NS; k++) begin
      if (src_we[k] && op != 0 && src_rd[k*AW +: AW] == op) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit hz();
    return idex_mem_read && idex_rd != 0 &&
           ((ifid_rs_used && ifid_rs == idex_rd) || (ifid_rt_used && ifid_rt == idex_rd));
  endfunction

  function automatic int exp_stall(input int i);
    return (!rst && !flush && (owed[i] > 0 || hz())) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        owed[i] <= 0;
        sc[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exp_stall(i) == 1 && sc[i] < 65535) sc[i] <= sc[i] + 1;
        if (flush) owed[i] <= 0;
        else if (owed[i] > 0) begin
          if (!freeze) owed[i] <= owed[i] - 1;
        end else if (hz()) owed[i] <= lat[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("fwd_a3", 32'(if3.forward_a), exp_fwd(idex_rs));
    check("fwd_b3", 32'(if3.forward_b), exp_fwd(idex_rt));
    check("fwd_a1", 32'(if1.forward_a), exp_fwd(idex_rs));
    check("stall3", 32'(if3.stall), exp_stall(0));
    check("bubble3", 32'(if3.bubble), exp_stall(0));
    check("stall1", 32'(if1.stall), exp_stall(1));
    check("bubble1", 32'(if1.bubble), exp_stall(1));
    check("cycles3", 32'(if3.stall_cycles), sc[0]);
    check("cycles1", 32'(if1.stall_cycles), sc[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_hazard(input logic on);
    idex_mem_read = on;
    idex_rd       = on ? 5'd9 : 5'd0;
    ifid_rs       = on ? 5'd9 : 5'd0;
    ifid_rs_used  = on;
  endtask

  initial begin
    // Hazard visible while reset is held must not stall.
    #12;
    set_load_hazard(1'b1);
    src_we = 2'b01; src_rd = {5'd0, 5'd7}; idex_rs = 5'd7;
    #1;
    check("rst_stall3", 32'(if3.stall), 0);
    check("rst_bubble1", 32'(if1.bubble), 0);
    check("rst_cycles3", 32'(if3.stall_cycles), 0);
    check("rst_fwd_a", 32'(if3.forward_a), 1);
    set_load_hazard(1'b0);
    tick();
    rst = 1'b0;
    tick();

    src_we = 2'b11; src_rd = {5'd8, 5'd8}; idex_rs = 5'd8;
    #1 check("fwd_youngest", 32'(if3.forward_a), 1);
    src_we = 2'b10;
    #1 check("fwd_older", 32'(if3.forward_a), 2);
    src_we = 2'b01; src_rd = '0; idex_rs = 5'd0;
    #1 check("fwd_r0", 32'(if3.forward_a), 0);
    src_we = 2'b11; src_rd = {5'd8, 5'd4}; idex_rt = 5'd8;
    #1 check("fwd_b_src1", 32'(if3.forward_b), 2);
    idex_rt = 5'd4;
    #1 check("fwd_b_src0", 32'(if3.forward_b), 1);
    src_we = '0; src_rd = '0; idex_rt = '0;
    tick();

    set_load_hazard(1'b1);
    #1;
    check("hz_stall1", 32'(if1.stall), 1);
    check("hz_bubble1", 32'(if1.bubble), 1);
    check("hz_stall3", 32'(if3.stall), 1);
    tick();
    set_load_hazard(1'b0);
    freeze = 1'b1;
    #1;
    check("lat1_done", 32'(if1.stall), 0);
    check("lat1_cycles", 32'(if1.stall_cycles), 1);
    check("frz_stall3", 32'(if3.stall), 1);
    tick();
    freeze = 1'b0;
    #1 check("frz_held3", 32'(if3.stall), 1);
    tick();
    #1 check("frz_last3", 32'(if3.stall), 1);
    tick();
    #1;
    check("frz_done3", 32'(if3.stall), 0);
    check("frz_cycles3", 32'(if3.stall_cycles), 4);

    set_load_hazard(1'b1);
    #1 check("fl_first", 32'(if3.stall), 1);
    tick();
    set_load_hazard(1'b0);
    flush = 1'b1;
    #1;
    check("fl_stall3", 32'(if3.stall), 0);
    check("fl_bubble3", 32'(if3.bubble), 0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_idle3", 32'(if3.stall), 0);
    check("fl_cycles3", 32'(if3.stall_cycles), 5);
    check("fl_cycles1", 32'(if1.stall_cycles), 2);

    set_load_hazard(1'b1);
    flush = 1'b1;
    #1;
    check("fl_prio3", 32'(if3.stall), 0);
    check("fl_prio1", 32'(if1.stall), 0);
    tick();
    set_load_hazard(1'b0);
    flush = 1'b0;
    #1 check("fl_prio_idle", 32'(if3.stall), 0);

    idex_mem_read = 1'b1; idex_rd = 5'd9; ifid_rt = 5'd9; ifid_rt_used = 1'b0;
    ifid_rs = 5'd3; ifid_rs_used = 1'b1;
    #1 check("rt_unused", 32'(if3.stall), 0);
    ifid_rt_used = 1'b1;
    #1 check("rt_used", 32'(if3.stall), 1);
    tick();
    idex_mem_read = 1'b0; ifid_rt_used = 1'b0; ifid_rs_used = 1'b0;
    #1 check("pre_rst_stall3", 32'(if3.stall), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall3", 32'(if3.stall), 0);
    check("mid_rst_cycles3", 32'(if3.stall_cycles), 0);
    check("mid_rst_cycles1", 32'(if1.stall_cycles), 0);
    tick();
    rst = 1'b0;

    set_load_hazard(1'b1);
    #1 check("post_rst_stall1", 32'(if1.stall), 1);
    repeat (70000) tick();
    check("sat_cycles1", 32'(if1.stall_cycles), 32'hFFFF);
    check("sat_cycles3", 32'(if3.stall_cycles), 32'hFFFF);
    set_load_hazard(1'b0);
    repeat (4) tick();
    check("sat_hold3", 32'(if3.stall_cycles), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
